// File: rtl/port_merge_rr_pkg.sv
// Shared types and helpers for the round-robin stream merger.
package port_merge_pkg;
  typedef enum logic {IDLE, LOCKED} merge_state_e;

  function automatic int chan_w(input int n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/port_merge_rr_if.sv
// N-to-1 merge bus: NUM_IN producer channels in, one registered stream out.
interface port_merge_rr_if
  import port_merge_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int WIDTH  = 8,
  parameter int CHAN_W = chan_w(NUM_IN)
) ();
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic [CHAN_W-1:0]       out_chan;
  logic                    out_last;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_chan, out_last
  );
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_chan, out_last
  );
endinterface

// File: rtl/port_merge_rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, wrapping to the lowest index.
module rr_arbiter
  import port_merge_pkg::*;
#(
  parameter int  NUM_IN = 4,
  localparam int CHAN_W = chan_w(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [CHAN_W-1:0] ptr,
  input  logic              en,
  output logic [NUM_IN-1:0] gnt,
  output logic [CHAN_W-1:0] gnt_idx
);
  logic w_found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    for (int j = 0; j < NUM_IN; j++) begin
      if (!w_found && req[j] && (j >= int'(ptr))) begin
        w_found = 1'b1;
        gnt_idx = CHAN_W'(j);
      end
    end
    // Nothing at or above ptr: wrap around to the lowest requester.
    for (int j = 0; j < NUM_IN; j++) begin
      if (!w_found && req[j]) begin
        w_found = 1'b1;
        gnt_idx = CHAN_W'(j);
      end
    end
    if (w_found && en) gnt[gnt_idx] = 1'b1;
  end
endmodule

// File: rtl/port_merge_rr.sv
// N-to-1 valid/ready merger with round-robin fairness, channel tagging and optional packet lock.
module port_merge_rr
  import port_merge_pkg::*;
#(
  parameter int NUM_IN   = 4,
  parameter int WIDTH    = 8,
  parameter int PKT_LOCK = 0
) (
  input logic             clk,
  input logic             rst,
  port_merge_rr_if.slave  bus
);
  localparam int CHAN_W = chan_w(NUM_IN);

  merge_state_e      r_state;
  logic [CHAN_W-1:0] r_ptr;
  logic [CHAN_W-1:0] r_lock_chan;
  logic              r_out_valid;
  logic [WIDTH-1:0]  r_out_data;
  logic [CHAN_W-1:0] r_out_chan;
  logic              r_out_last;

  logic              w_load_en;
  logic              w_locked;
  logic [NUM_IN-1:0] w_req;
  logic [CHAN_W-1:0] w_arb_ptr;
  logic [NUM_IN-1:0] w_gnt;
  logic [CHAN_W-1:0] w_gidx;
  logic [CHAN_W-1:0] w_next;
  logic              w_accept;
  logic [WIDTH-1:0]  w_data;
  logic              w_last;

  assign w_load_en = !r_out_valid || bus.out_ready;
  assign w_locked  = (PKT_LOCK != 0) && (r_state == LOCKED);
  // While locked, everyone but the owning channel is masked out of arbitration.
  assign w_req     = w_locked ? (bus.in_valid & (NUM_IN'(1) << r_lock_chan)) : bus.in_valid;
  assign w_arb_ptr = w_locked ? r_lock_chan : r_ptr;

  rr_arbiter #(.NUM_IN(NUM_IN)) u_arb (
    .req     (w_req),
    .ptr     (w_arb_ptr),
    .en      (w_load_en),
    .gnt     (w_gnt),
    .gnt_idx (w_gidx)
  );

  assign w_accept     = |w_gnt;
  assign w_next       = (w_gidx == CHAN_W'(NUM_IN - 1)) ? '0 : w_gidx + 1'b1;
  assign bus.in_ready = w_gnt;

  always_comb begin
    w_data = '0;
    w_last = 1'b0;
    for (int j = 0; j < NUM_IN; j++) begin
      if (w_gnt[j]) begin
        w_data = bus.in_data[j*WIDTH +: WIDTH];
        w_last = bus.in_last[j];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_lock_chan <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_data;
      r_out_chan  <= w_gidx;
      r_out_last  <= (PKT_LOCK == 0) ? 1'b1 : w_last;
      if (PKT_LOCK == 0 || w_last) begin
        // Closing beat (or single beat): advance past the granted channel.
        r_state <= IDLE;
        r_ptr   <= w_next;
      end else if (r_state == IDLE) begin
        r_state     <= LOCKED;
        r_lock_chan <= w_gidx;
      end
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_chan  = r_out_chan;
  assign bus.out_last  = r_out_last;
endmodule

// File: tb/tb_port_merge_rr.sv
// Scoreboard bench for port_merge_rr: three instances cover free RR, packet lock and the 2x1 corner.
module tb_port_merge_rr;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] chan;
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  port_merge_rr_if #(.NUM_IN(3), .WIDTH(8)) bus_a ();
  port_merge_rr_if #(.NUM_IN(3), .WIDTH(8)) bus_b ();
  port_merge_rr_if #(.NUM_IN(2), .WIDTH(1)) bus_c ();

  port_merge_rr #(.NUM_IN(3), .WIDTH(8), .PKT_LOCK(0)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  port_merge_rr #(.NUM_IN(3), .WIDTH(8), .PKT_LOCK(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  port_merge_rr #(.NUM_IN(2), .WIDTH(1), .PKT_LOCK(0)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic exp_t mk(input int c, input logic [7:0] d, input logic l);
    exp_t e;
    e.chan = 4'(c);
    e.data = d;
    e.last = l;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every beat the downstream takes is popped and compared.
  always @(negedge clk) begin
    exp_t e;
    if (bus_a.out_valid && bus_a.out_ready) begin
      chk("a_avail", 32'(q_a.size() != 0), 1);
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        chk("a_chan", 32'(bus_a.out_chan), 32'(e.chan));
        chk("a_data", 32'(bus_a.out_data), 32'(e.data));
        chk("a_last", 32'(bus_a.out_last), 32'(e.last));
      end
    end
    if (bus_b.out_valid && bus_b.out_ready) begin
      chk("b_avail", 32'(q_b.size() != 0), 1);
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        chk("b_chan", 32'(bus_b.out_chan), 32'(e.chan));
        chk("b_data", 32'(bus_b.out_data), 32'(e.data));
        chk("b_last", 32'(bus_b.out_last), 32'(e.last));
      end
    end
    if (bus_c.out_valid && bus_c.out_ready) begin
      chk("c_avail", 32'(q_c.size() != 0), 1);
      if (q_c.size() != 0) begin
        e = q_c.pop_front();
        chk("c_chan", 32'(bus_c.out_chan), 32'(e.chan));
        chk("c_data", 32'(bus_c.out_data), 32'(e.data));
        chk("c_last", 32'(bus_c.out_last), 32'(e.last));
      end
    end
  end

  initial begin
    bus_a.in_valid = '0; bus_a.in_data = '0; bus_a.in_last = '0; bus_a.out_ready = 1'b1;
    bus_b.in_valid = '0; bus_b.in_data = '0; bus_b.in_last = '0; bus_b.out_ready = 1'b1;
    bus_c.in_valid = '0; bus_c.in_data = '0; bus_c.in_last = '0; bus_c.out_ready = 1'b1;
    step();
    step();
    chk("rst_a_valid", 32'(bus_a.out_valid), 0);
    chk("rst_a_data",  32'(bus_a.out_data), 0);
    chk("rst_a_chan",  32'(bus_a.out_chan), 0);
    chk("rst_a_last",  32'(bus_a.out_last), 0);
    chk("rst_b_valid", 32'(bus_b.out_valid), 0);
    chk("rst_a_ready", 32'(bus_a.in_ready), 0);
    rst = 1'b0;

    // All three valid: strict 0,1,2 rotation at full rate.
    bus_a.in_data  = {8'hC2, 8'hB1, 8'hA0};
    bus_a.in_valid = 3'b111;
    for (int i = 0; i < 6; i++) q_a.push_back(mk(i % 3, 8'hA0 + 8'(i % 3) * 8'h11, 1'b1));
    for (int i = 0; i < 6; i++) begin
      step();
      @(negedge clk);
      chk("a_nobubble", 32'(bus_a.out_valid), 1);
    end

    // Lone channel 2 repeatedly, then lone channel 0 right after the wrap.
    bus_a.in_valid = 3'b100;
    bus_a.in_data  = {8'h5C, 8'h00, 8'h00};
    for (int i = 0; i < 3; i++) q_a.push_back(mk(2, 8'h5C, 1'b1));
    q_a.push_back(mk(0, 8'h11, 1'b1));
    repeat (3) step();
    bus_a.in_valid = 3'b001;
    bus_a.in_data  = {8'h00, 8'h00, 8'h11};
    step();
    bus_a.in_valid = 3'b000;

    // Backpressure: hold the 0x33 beat for four cycles.
    step();
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 3'b010;
    bus_a.in_data   = {8'h00, 8'h33, 8'h00};
    q_a.push_back(mk(1, 8'h33, 1'b1));
    q_a.push_back(mk(2, 8'h42, 1'b1));
    step();
    bus_a.in_valid = 3'b111;
    bus_a.in_data  = {8'h42, 8'h41, 8'h40};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("a_bp_ready", 32'(bus_a.in_ready), 0);
      chk("a_bp_data",  32'(bus_a.out_data), 32'h33);
    end
    @(posedge clk);
    #1;
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    chk("a_rel_ready", 32'(bus_a.in_ready), 32'b100);
    @(posedge clk);
    #1;
    bus_a.in_valid = 3'b000;
    step();

    // Packet lock: ch1 owns the output for three beats despite competitors.
    bus_b.in_valid = 3'b010;
    bus_b.in_data  = {8'h00, 8'h10, 8'h00};
    bus_b.in_last  = 3'b000;
    q_b.push_back(mk(1, 8'h10, 1'b0));
    q_b.push_back(mk(1, 8'h11, 1'b0));
    q_b.push_back(mk(1, 8'h12, 1'b1));
    q_b.push_back(mk(2, 8'h22, 1'b1));
    q_b.push_back(mk(0, 8'h20, 1'b1));
    step();
    bus_b.in_valid = 3'b111;
    bus_b.in_data  = {8'h22, 8'h11, 8'h20};
    bus_b.in_last  = 3'b101;
    @(negedge clk);
    chk("b_lock_ready", 32'(bus_b.in_ready), 32'b010);
    step();
    bus_b.in_data = {8'h22, 8'h12, 8'h20};
    bus_b.in_last = 3'b111;
    step();
    bus_b.in_valid = 3'b101;
    step();
    bus_b.in_valid = 3'b001;
    step();
    bus_b.in_valid = 3'b000;
    step();

    // Reset in the middle of a locked packet drops the held beat and the lock.
    bus_b.out_ready = 1'b0;
    bus_b.in_valid  = 3'b100;
    bus_b.in_data   = {8'h55, 8'h00, 8'h00};
    bus_b.in_last   = 3'b000;
    step();
    bus_b.in_valid = 3'b101;
    bus_b.in_data  = {8'h62, 8'h00, 8'h60};
    bus_b.in_last  = 3'b101;
    @(negedge clk);
    chk("b_held_valid", 32'(bus_b.out_valid), 1);
    chk("b_held_ready", 32'(bus_b.in_ready), 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("b_rst_valid", 32'(bus_b.out_valid), 0);
    chk("b_rst_chan",  32'(bus_b.out_chan), 0);
    chk("b_rst_ready", 32'(bus_b.in_ready), 32'b001);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus_b.out_ready = 1'b1;
    q_b.push_back(mk(0, 8'h60, 1'b1));
    q_b.push_back(mk(2, 8'h62, 1'b1));
    step();
    bus_b.in_valid = 3'b100;
    step();
    bus_b.in_valid = 3'b000;
    step();

    // Two 1-bit channels alternate.
    bus_c.in_valid = 2'b11;
    bus_c.in_data  = 2'b01;
    q_c.push_back(mk(0, 8'h01, 1'b1));
    q_c.push_back(mk(1, 8'h00, 1'b1));
    q_c.push_back(mk(0, 8'h01, 1'b1));
    repeat (3) step();
    bus_c.in_valid = 2'b00;

    repeat (3) step();
    chk("a_drain", 32'(q_a.size()), 0);
    chk("b_drain", 32'(q_b.size()), 0);
    chk("c_drain", 32'(q_c.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/port_merge_rr.md
# port_merge_rr

Parametrised N-to-1 stream merger: collects NUM_IN valid/ready input channels of WIDTH bits into one registered output stream with round-robin fairness, source-channel tagging and optional packet locking. Sits between per-port producer blocks and a single shared downstream consumer. Generalises the fixed two-input/one-output port shape to an arbitrary channel count with flow control.

## Interface
- NUM_IN, 4, number of input channels (2..16)
- WIDTH, 8, data width per channel (1..64)
- PKT_LOCK, 0, 1 = hold grant on a channel until its in_last beat is accepted
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset; asynchronous, active-high
- in_valid  input  NUM_IN  per-channel valid
- in_ready  output  NUM_IN  per-channel ready (one-hot or zero)
- in_data  input  NUM_IN*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
- in_last  input  NUM_IN  end-of-packet flag per channel (ignored when PKT_LOCK=0)
- out_valid  output  1  output register holds a beat
- out_ready  input  1  downstream accepts
- out_data  output  WIDTH  registered data
- out_chan  output  CHAN_W  source channel of out_data
- out_last  output  1  registered in_last of the beat (1 when PKT_LOCK=0)

## Operation
- Output stage: one register slot. load_en = !out_valid || out_ready. Full throughput: one beat per cycle when out_ready stays high.
- Arbiter: when load_en, grant the first valid channel at or after ptr (modulo NUM_IN). in_ready = grant one-hot gated by load_en; zero when no channel valid.
- Accept (in_valid[g] && in_ready[g]): load out_data/out_chan/out_last, set out_valid; ptr <= (g+1) mod NUM_IN. Wrap from NUM_IN-1 to 0.
- No accept and out_ready high: out_valid <= 0.
- PKT_LOCK=1, FSM states IDLE, LOCKED:
  - IDLE: normal round-robin; accepting a beat with in_last=0 -> LOCKED, lock_chan <= g, ptr unchanged.
  - LOCKED: only lock_chan may be granted; others see in_ready=0 even if valid. Accepting a beat with in_last=1 -> IDLE, ptr <= lock_chan+1.
  - Single-beat packet (in_last=1 in IDLE) behaves as PKT_LOCK=0.
- Simultaneous out_ready and new accept in the same cycle: register replaced, out_valid stays 1, no bubble.
- in_valid deassertion by a producer without handshake is legal; arbiter re-evaluates every cycle.
- Reset: out_valid=0, out_data=0, out_chan=0, out_last=0, ptr=0, state=IDLE. Asynchronous assertion mid-packet drops the held beat and lock; in_ready combinationally reflects the reset state (grant from ptr=0).

## Timing
- Input-to-output latency: 1 cycle (beat accepted at edge k visible on out_* after edge k).
- in_ready depends combinationally on in_valid, out_valid, out_ready, ptr, state; no combinational path in_data -> out_*.
- Backpressure: out_ready=0 with out_valid=1 forces all in_ready=0 in the same cycle; out_* held stable.
- Fairness bound: a continuously valid channel is granted within NUM_IN accepts (PKT_LOCK=0).

## Structure
- Package port_merge_pkg: function chan_w(n) = max(1, $clog2(n)); typedef enum logic {IDLE, LOCKED} merge_state_e.
- Sub-module rr_arbiter (NUM_IN; inputs req, ptr, en; output gnt one-hot, gnt_idx); instantiated once. Register/FSM logic in port_merge_rr.

## Test plan
- NUM_IN=3, WIDTH=8, out_ready=1, all channels valid with data 8'hA0/8'hB1/8'hC2 -> out_chan sequence 0,1,2,0,1,2, one beat per cycle, no bubbles.
- Only channel 2 valid (8'h5C), out_ready=1 -> out_chan=2 every cycle; ptr wraps to 0; then channel 0 valid alone granted next cycle.
- out_valid=1, out_ready held 0 for 4 cycles -> in_ready=3'b000, out_data stable; release -> next beat appears 1 cycle later.
- PKT_LOCK=1: ch1 sends 3-beat packet (last on beat 3) while ch0 and ch2 valid -> out_chan 1,1,1, then 2, then 0.
- Reset asserted in LOCKED mid-packet -> out_valid=0 immediately, after release grant restarts at ch0.
- NUM_IN=2, WIDTH=1 corner: chan_w=1, alternating grants 0,1,0 with both valid.
